best_arr_out_sched: RTL and testbench

- Sequences readout of the best-match index array (one word per query patch) into the output FIFO after the main algorithm finishes.
- Triggered by a send_best_arr pulse at top level.
- Generates read addresses in the column-blocked order the host reconstructs against.
- Handles 1-cycle memory read latency and output-FIFO backpressure with a skid register. No word is lost or duplicated.

---
 rtl/best_arr_out_sched.sv | 181 ++++++++++++++++++
 tb/tb_best_arr_out_sched.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/best_arr_out_sched.sv
// Streams the best-match index array into the output FIFO in column-blocked order.
// Optional BEST_ARR_OUT_CHECKSUM_EN appends one XOR-of-all-words checksum word.
module best_arr_out_sched #(
    parameter int unsigned DATA_WIDTH = 11,
    parameter int unsigned ROW_SIZE   = 26,
    parameter int unsigned COL_SIZE   = 19,
    parameter int unsigned BLOCKING   = 4,
    parameter int unsigned ADDR_WIDTH = $clog2(ROW_SIZE * COL_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_ren,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  fifo_wenq,
    output logic [DATA_WIDTH-1:0] fifo_wdata,
    input  logic                  fifo_wfull_n
);

    localparam int unsigned HALF   = ROW_SIZE / 2;
    localparam int unsigned NUM_X  = (HALF + BLOCKING - 1) / BLOCKING;
    localparam int unsigned LAST_W = HALF - (NUM_X - 1) * BLOCKING;
    localparam int unsigned TOTAL  = ROW_SIZE * COL_SIZE;
    localparam int unsigned XW     = (NUM_X > 1) ? $clog2(NUM_X) : 1;
    localparam int unsigned YW     = (COL_SIZE > 1) ? $clog2(COL_SIZE) : 1;
    localparam int unsigned IW     = (BLOCKING > 1) ? $clog2(BLOCKING) : 1;
    localparam int unsigned CW     = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StCsum} state_e;

    state_e                 state;
    logic                   px;
    logic [XW-1:0]          x;
    logic [YW-1:0]          y;
    logic [IW-1:0]          xi;
    logic                   rd_valid;
    logic                   skid_valid;
    logic [DATA_WIDTH-1:0]  skid_data;
    logic [CW-1:0]          enq_cnt;
    logic                   x_last;
    logic                   y_last;
    logic                   xi_last;
    logic                   last_addr;
    logic                   last_enq;
    logic                   csum_phase;
`ifdef BEST_ARR_OUT_CHECKSUM_EN
    logic [DATA_WIDTH-1:0]  csum;
`endif

    // Odometer wrap points; the final x block may be narrower than BLOCKING.
    assign x_last    = (x == XW'(NUM_X - 1));
    assign y_last    = (y == YW'(COL_SIZE - 1));
    assign xi_last   = x_last ? (xi == IW'(LAST_W - 1)) : (xi == IW'(BLOCKING - 1));
    assign last_addr = px && x_last && y_last && xi_last;

    assign mem_ren   = (state == StRun) && fifo_wfull_n && !skid_valid;
    assign mem_raddr = ADDR_WIDTH'((px ? HALF : 0) + ROW_SIZE * 32'(y)
                                   + BLOCKING * 32'(x) + 32'(xi));

`ifdef BEST_ARR_OUT_CHECKSUM_EN
    assign csum_phase = (state == StCsum);
`else
    assign csum_phase = 1'b0;
`endif

    assign fifo_wenq = fifo_wfull_n && (skid_valid || rd_valid || csum_phase);
    assign last_enq  = fifo_wenq && !csum_phase && (enq_cnt == CW'(TOTAL - 1));

    always_comb begin
        fifo_wdata = '0;
        if (fifo_wenq) begin
            if (skid_valid) begin
                fifo_wdata = skid_data;
            end else if (rd_valid) begin
                fifo_wdata = mem_rdata;
            end else begin
`ifdef BEST_ARR_OUT_CHECKSUM_EN
                fifo_wdata = csum;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            busy       <= 1'b0;
            done       <= 1'b0;
            px         <= 1'b0;
            x          <= '0;
            y          <= '0;
            xi         <= '0;
            rd_valid   <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            enq_cnt    <= '0;
`ifdef BEST_ARR_OUT_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            done     <= 1'b0;
            rd_valid <= mem_ren;

            // A read returning into a stalled FIFO parks in the skid register;
            // no new read is issued until it drains, so at most one word is in flight.
            if (rd_valid && !fifo_wfull_n) begin
                skid_valid <= 1'b1;
                skid_data  <= mem_rdata;
            end else if (skid_valid && fifo_wfull_n) begin
                skid_valid <= 1'b0;
            end

            if (fifo_wenq && !csum_phase) begin
                enq_cnt <= enq_cnt + CW'(1);
`ifdef BEST_ARR_OUT_CHECKSUM_EN
                csum    <= csum ^ fifo_wdata;
`endif
            end

            if (mem_ren) begin
                if (!xi_last) begin
                    xi <= xi + IW'(1);
                end else begin
                    xi <= '0;
                    if (!y_last) begin
                        y <= y + YW'(1);
                    end else begin
                        y <= '0;
                        if (!x_last) begin
                            x <= x + XW'(1);
                        end else begin
                            x  <= '0;
                            px <= ~px;
                        end
                    end
                end
            end

            unique case (state)
                StIdle: begin
                    if (start) begin
                        state   <= StRun;
                        busy    <= 1'b1;
                        enq_cnt <= '0;
`ifdef BEST_ARR_OUT_CHECKSUM_EN
                        csum    <= '0;
`endif
                    end
                end
                StRun: begin
                    if (mem_ren && last_addr) begin
                        state <= StDrain;
                    end
                end
                StDrain: begin
                    if (last_enq) begin
`ifdef BEST_ARR_OUT_CHECKSUM_EN
                        state <= StCsum;
`else
                        state <= StIdle;
                        busy  <= 1'b0;
                        done  <= 1'b1;
`endif
                    end
                end
                StCsum: begin
                    if (fifo_wenq) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_best_arr_out_sched.sv
// Randomized self-checking bench for best_arr_out_sched against a loop-order reference model.
// Honours BEST_ARR_OUT_CHECKSUM_EN to expect the trailing checksum word.
module tb_best_arr_out_sched;

    localparam int unsigned DW     = 11;
    localparam int unsigned ROW    = 26;
    localparam int unsigned COL    = 19;
    localparam int unsigned BLK    = 4;
    localparam int unsigned AW     = $clog2(ROW * COL);
    localparam int unsigned TOTAL  = ROW * COL;
    localparam int unsigned ROW2   = 16;
    localparam int unsigned COL2   = 3;
    localparam int unsigned BLK2   = 4;
    localparam int unsigned AW2    = $clog2(ROW2 * COL2);
    localparam int unsigned TOTAL2 = ROW2 * COL2;
`ifdef BEST_ARR_OUT_CHECKSUM_EN
    localparam int unsigned EXTRA  = 1;
`else
    localparam int unsigned EXTRA  = 0;
`endif
    localparam int unsigned NWORDS  = TOTAL + EXTRA;
    localparam int unsigned NWORDS2 = TOTAL2 + EXTRA;

    logic          clk, rst_n, start, busy, done, mem_ren, fifo_wenq, fifo_wfull_n;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_rdata, fifo_wdata;

    logic           start2, busy2, done2, mem_ren2, fifo_wenq2, fifo_wfull_n2;
    logic [AW2-1:0] mem_raddr2;
    logic [DW-1:0]  mem_rdata2, fifo_wdata2;

    best_arr_out_sched #(
        .DATA_WIDTH(DW), .ROW_SIZE(ROW), .COL_SIZE(COL), .BLOCKING(BLK), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .fifo_wenq(fifo_wenq), .fifo_wdata(fifo_wdata), .fifo_wfull_n(fifo_wfull_n)
    );

    best_arr_out_sched #(
        .DATA_WIDTH(DW), .ROW_SIZE(ROW2), .COL_SIZE(COL2), .BLOCKING(BLK2), .ADDR_WIDTH(AW2)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
        .mem_ren(mem_ren2), .mem_raddr(mem_raddr2), .mem_rdata(mem_rdata2),
        .fifo_wenq(fifo_wenq2), .fifo_wdata(fifo_wdata2), .fifo_wfull_n(fifo_wfull_n2)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int nidx, done_cnt, first_enq, last_enq, done_cyc, s_cyc, bp_mode;
    int addr_q[$], addr2_q[$], exp_q[$], got_q[$], got2_q[$];
    int done2_cnt;
    logic [DW-1:0] mem [0:TOTAL-1];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Reference order straight from the nested-loop definition.
    function automatic void build_addrs(input int row, input int col, input int blk,
                                        output int q[$]);
        int half, nx, lw;
        half = row / 2;
        nx   = (half + blk - 1) / blk;
        lw   = half - (nx - 1) * blk;
        q    = {};
        for (int p = 0; p < 2; p++)
            for (int xx = 0; xx < nx; xx++)
                for (int yy = 0; yy < col; yy++)
                    for (int ii = 0; ii < blk; ii++)
                        if (!(xx == nx - 1 && ii >= lw))
                            q.push_back(p * half + yy * row + xx * blk + ii);
    endfunction

    // Synchronous-read memories with one cycle of latency.
    always @(posedge clk) begin
        if (mem_ren) mem_rdata <= mem[mem_raddr];
        if (mem_ren2) mem_rdata2 <= DW'(mem_raddr2);
    end

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            chk("reset_outputs", {8'd0, busy, done, mem_ren, mem_raddr, fifo_wenq, fifo_wdata},
                32'd0);
            nidx = 0; done_cnt = 0; first_enq = -1; last_enq = -1; done_cyc = -1;
            got_q = {}; got2_q = {}; done2_cnt = 0;
        end else begin
            chk("skid_rd_exclusive", {31'd0, dut.skid_valid & dut.rd_valid}, 32'd0);
            if (!fifo_wfull_n) begin
                chk("ren_when_full", {31'd0, mem_ren}, 32'd0);
                chk("wenq_when_full", {31'd0, fifo_wenq}, 32'd0);
            end
            if (fifo_wenq) begin
                if (nidx == 0) first_enq = cyc;
                last_enq = cyc;
                if (nidx < exp_q.size()) chk($sformatf("word[%0d]", nidx), 32'(fifo_wdata),
                                             exp_q[nidx]);
                else chk("extra_word", 32'(nidx), exp_q.size());
                got_q.push_back(int'(fifo_wdata));
                nidx++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_after_all", 32'(nidx), NWORDS);
            end
            if (fifo_wenq2) got2_q.push_back(int'(fifo_wdata2));
            if (done2) done2_cnt++;
        end
    end

    // Backpressure driver: 0 = always ready, 1 = scripted burst + every third cycle, 2 = random.
    initial begin
        bit burst_done;
        int burst_left;
        fifo_wfull_n  = 1'b1;
        fifo_wfull_n2 = 1'b1;
        burst_done = 0;
        burst_left = 0;
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                1: begin
                    if (nidx >= 100 && !burst_done) begin
                        burst_done = 1;
                        burst_left = 5;
                    end
                    if (burst_left > 0) begin
                        fifo_wfull_n = 1'b0;
                        burst_left--;
                    end else begin
                        fifo_wfull_n = (cyc % 3 != 0);
                    end
                end
                2: fifo_wfull_n = ($urandom_range(0, 3) != 0);
                default: begin
                    fifo_wfull_n = 1'b1;
                    burst_done   = 0;
                end
            endcase
        end
    end

    task automatic prepare(input bit rnd);
        int x;
        for (int i = 0; i < int'(TOTAL); i++) mem[i] = rnd ? DW'($urandom) : DW'(i);
        exp_q = {};
        x = 0;
        foreach (addr_q[i]) begin
            exp_q.push_back(int'(mem[addr_q[i]]));
            x = x ^ int'(mem[addr_q[i]]);
        end
        if (EXTRA != 0) exp_q.push_back(x);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        s_cyc = cyc + 1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_words(input int n);
        int k = 0;
        while (nidx < n && k < 20000) begin
            @(posedge clk);
            k++;
        end
        chk("wait_words_timeout", {31'd0, nidx >= n}, 32'd1);
    endtask

    task automatic run_seq(input int mode, input bit rnd, input bit dbl_start);
        int k;
        bp_mode = 0;
        prepare(rnd);
        do_reset();
        bp_mode = mode;
        pulse_start();
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        if (dbl_start) begin
            wait_words(50);
            #1 start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        k = 0;
        while (done_cnt == 0 && k < 20000) begin
            @(negedge clk);
            #1 k++;
        end
        repeat (6) @(negedge clk);
        #1;
        bp_mode = 0;
        chk("word_count", 32'(nidx), NWORDS);
        chk("done_pulses", 32'(done_cnt), 32'd1);
        chk("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int x2;
        rst_n = 1'b0; start = 1'b0; start2 = 1'b0; bp_mode = 0;
        mem_rdata = '0; mem_rdata2 = '0;
        build_addrs(ROW, COL, BLK, addr_q);
        build_addrs(ROW2, COL2, BLK2, addr2_q);

        // Pin the reference model with hand-derived positions.
        chk("model_len", 32'(addr_q.size()), TOTAL);
        chk("model_w4", 32'(addr_q[4]), 32'd26);
        chk("model_w76", 32'(addr_q[76]), 32'd4);
        chk("model_w229", 32'(addr_q[229]), 32'd38);
        chk("model_w247", 32'(addr_q[247]), 32'd13);
        chk("model2_w24", 32'(addr2_q[24]), 32'd8);

        // Ordering at full throughput with rdata = addr.
        run_seq(0, 0, 0);
        chk("first_enq_lat", 32'(first_enq - s_cyc), 32'd2);
        chk("burst_span", 32'(last_enq - first_enq), NWORDS - 1);
        chk("done_lat", 32'(done_cyc - last_enq), 32'd1);
        for (int i = 0; i < 8; i++) begin
            int e;
            e = (i < 4) ? i : 22 + i;
            chk($sformatf("lit_w%0d", i), 32'(got_q[i]), 32'(e));
        end
        chk("lit_w76", 32'(got_q[76]), 32'd4);
        chk("lit_w228", 32'(got_q[228]), 32'd12);
        chk("lit_w229", 32'(got_q[229]), 32'd38);
        chk("lit_w247", 32'(got_q[247]), 32'd13);
        chk("lit_w493", 32'(got_q[493]), 32'd493);
        if (EXTRA != 0) chk("lit_checksum", 32'(got_q[494]), 32'd1);

        // Scripted backpressure, then random backpressure on random data.
        run_seq(1, 0, 0);
        run_seq(2, 1, 0);

        // Start while busy must be ignored.
        run_seq(0, 1, 1);

        // Asynchronous reset mid-run, then a fresh full run.
        bp_mode = 0;
        prepare(0);
        do_reset();
        pulse_start();
        wait_words(300);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_out", {8'd0, busy, done, mem_ren, mem_raddr, fifo_wenq, fifo_wdata},
            32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        pulse_start();
        begin
            int k = 0;
            while (done_cnt == 0 && k < 20000) begin
                @(negedge clk);
                #1 k++;
            end
        end
        repeat (4) @(negedge clk);
        #1;
        chk("post_reset_count", 32'(nidx), NWORDS);
        chk("post_reset_w3", 32'(got_q[3]), 32'd3);

        // Second instance with the smaller geometry.
        @(posedge clk);
        #1 start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        begin
            int k = 0;
            while (done2_cnt == 0 && k < 2000) begin
                @(negedge clk);
                #1 k++;
            end
        end
        repeat (4) @(negedge clk);
        #1;
        chk("sweep_count", 32'(got2_q.size()), NWORDS2);
        chk("sweep_done", 32'(done2_cnt), 32'd1);
        if (got2_q.size() >= int'(TOTAL2)) begin
            chk("sweep_w12", 32'(got2_q[12]), 32'd4);
            chk("sweep_w24", 32'(got2_q[24]), 32'd8);
            x2 = 0;
            for (int i = 0; i < int'(TOTAL2); i++) begin
                chk($sformatf("sweep_word[%0d]", i), 32'(got2_q[i]), 32'(addr2_q[i]));
                x2 = x2 ^ addr2_q[i];
            end
            if (EXTRA != 0 && got2_q.size() > int'(TOTAL2))
                chk("sweep_checksum", 32'(got2_q[TOTAL2]), 32'(x2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
